pipeline_stage_buffer: RTL and testbench

PIPELINE_STAGE_BUFFER -- requirements
Module: pipeline_stage_buffer

---
 rtl/pipeline_stage_buffer.sv | 134 +++++++++++++
 tb/tb_pipeline_stage_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage_buffer.sv
// pipeline_stage_buffer: a two-entry elastic buffer (head + skid) between
// pipeline stages. It carries the instruction word and PC+4 and presents a
// NOP bubble (FLUSH_VAL) whenever it is empty. Flush discards both entries
// and Stall freezes the stage. BubbleCount is a saturating count of the
// cycles in which downstream wanted data but none was available.
module pipeline_stage_buffer #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              InReady,
  output logic              OutValid,
  output logic [DATA_W-1:0] OutData,
  input  logic              OutReady,
  input  logic              Flush,
  input  logic              Stall,
  output logic [1:0]        Count,
  output logic [CNT_W-1:0]  BubbleCount
);

  // The state encoding is the occupancy, so Count comes straight off the
  // state register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  head_q;
  logic [DATA_W-1:0]  skid_q;
  logic [CNT_W-1:0]   bubble_q;

  logic               enq;
  logic               deq;
  logic               bubble_evt;

  // Handshake qualifiers. Flush and Stall both close the input, and a full
  // buffer never accepts, so the occupancy cannot pass two.
  assign InReady    = !Flush && !Stall && (state_q != FULL);
  assign enq        = InValid && InReady;
  assign deq        = out_valid_q && OutReady && !Stall && !Flush;
  assign bubble_evt = OutReady && !out_valid_q && !Stall;

  assign Count       = state_q;
  assign OutValid    = out_valid_q;
  assign OutData     = head_q;
  assign BubbleCount = bubble_q;

  // Occupancy FSM and payload storage. Flush outranks Stall, which outranks
  // any enqueue or dequeue. Every transition into EMPTY reloads the head with
  // FLUSH_VAL, so OutData shows the bubble directly from the register.
  // NOTE: the two payload entries are ordinary flops and get reset like the
  // rest of the state, so the bubble value appears on OutData the moment
  // Reset_n falls instead of whatever was left over.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: all state here uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      head_q      <= FLUSH_VAL;
      skid_q      <= FLUSH_VAL;
    end else if (Flush) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      head_q      <= FLUSH_VAL;
      skid_q      <= FLUSH_VAL;
    end else if (!Stall) begin
      case (state_q)
        EMPTY: begin
          if (enq) begin
            state_q     <= ONE;
            out_valid_q <= 1'b1;
            head_q      <= InData;
          end
        end
        ONE: begin
          case ({enq, deq})
            2'b10: begin
              // Head is still waiting; the newcomer parks in the skid.
              state_q <= FULL;
              skid_q  <= InData;
            end
            2'b01: begin
              state_q     <= EMPTY;
              out_valid_q <= 1'b0;
              head_q      <= FLUSH_VAL;
            end
            2'b11: begin
              // Head leaves and the new entry takes its place in one edge.
              head_q <= InData;
            end
            default: begin
              // Neither side moved; hold.
            end
          endcase
        end
        FULL: begin
          if (deq) begin
            state_q <= ONE;
            head_q  <= skid_q;
            skid_q  <= FLUSH_VAL;
          end
        end
        default: begin
          // Unused encoding: fall back to a clean empty buffer.
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          head_q      <= FLUSH_VAL;
          skid_q      <= FLUSH_VAL;
        end
      endcase
    end
  end

  // Saturating bubble counter. It follows OutReady against the registered
  // OutValid and ignores Flush, so flushes do not hide starvation cycles.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bubble_q <= '0;
    end else if (bubble_evt && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_q <= bubble_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Directed bench for pipeline_stage_buffer: a table of per-cycle vectors
// for streaming, backpressure, stall, flush and ordering, plus hand-written
// sequences for reset behaviour and bubble-counter saturation.
module tb_pipeline_stage_buffer;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  logic              Clock;
  logic              Reset_n;
  logic              InValid;
  logic [DATA_W-1:0] InData;
  logic              InReady;
  logic              OutValid;
  logic [DATA_W-1:0] OutData;
  logic              OutReady;
  logic              Flush;
  logic              Stall;
  logic [1:0]        Count;
  logic [CNT_W-1:0]  BubbleCount;

  // Second instance with a 2-bit counter for the saturation check.
  logic              sat_rst_n;
  logic              sat_in_ready;
  logic              sat_out_valid;
  logic [7:0]        sat_out_data;
  logic              sat_out_ready;
  logic [1:0]        sat_count;
  logic [1:0]        sat_bubble;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        r;
    logic        f;
    logic        s;
    logic        ir;   // InReady during the cycle
    logic [1:0]  cnt;  // after the edge
    logic        ov;
    logic [63:0] od;
    logic [15:0] bc;
  } vec_t;

  vec_t vecs[$];

  pipeline_stage_buffer #(.DATA_W(DATA_W), .FLUSH_VAL('0), .CNT_W(CNT_W)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .InValid    (InValid),
    .InData     (InData),
    .InReady    (InReady),
    .OutValid   (OutValid),
    .OutData    (OutData),
    .OutReady   (OutReady),
    .Flush      (Flush),
    .Stall      (Stall),
    .Count      (Count),
    .BubbleCount(BubbleCount)
  );

  pipeline_stage_buffer #(.DATA_W(8), .FLUSH_VAL('0), .CNT_W(2)) dut_sat (
    .Clock      (Clock),
    .Reset_n    (sat_rst_n),
    .InValid    (1'b0),
    .InData     (8'h00),
    .InReady    (sat_in_ready),
    .OutValid   (sat_out_valid),
    .OutData    (sat_out_data),
    .OutReady   (sat_out_ready),
    .Flush      (1'b0),
    .Stall      (1'b0),
    .Count      (sat_count),
    .BubbleCount(sat_bubble)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [63:0] d, input logic r,
                     input logic f, input logic s, input logic ir,
                     input logic [1:0] cnt, input logic ov,
                     input logic [63:0] od, input logic [15:0] bc);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.f = f; t.s = s;
    t.ir = ir; t.cnt = cnt; t.ov = ov; t.od = od; t.bc = bc;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic r,
                       input logic f, input logic s);
    InValid = v; InData = d; OutReady = r; Flush = f; Stall = s;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //  v  data  r  f  s | ir cnt ov out  bubble
    // Streaming 1,2,3 with OutReady held high
    add(1, 64'h1, 1, 0, 0,  1, 1, 1, 64'h1, 1);
    add(1, 64'h2, 1, 0, 0,  1, 1, 1, 64'h2, 1);
    add(1, 64'h3, 1, 0, 0,  1, 1, 1, 64'h3, 1);
    add(0, 64'h0, 1, 0, 0,  1, 0, 0, 64'h0, 1);
    // Backpressure: A, B fill the buffer, C is refused, then drain
    add(1, 64'hA, 0, 0, 0,  1, 1, 1, 64'hA, 1);
    add(1, 64'hB, 0, 0, 0,  1, 2, 1, 64'hA, 1);
    add(1, 64'hC, 0, 0, 0,  0, 2, 1, 64'hA, 1);
    add(0, 64'h0, 1, 0, 0,  0, 1, 1, 64'hB, 1);
    add(0, 64'h0, 1, 0, 0,  1, 0, 0, 64'h0, 1);
    add(0, 64'h0, 1, 0, 0,  1, 0, 0, 64'h0, 2);
    // Stall hold with A in the head
    add(1, 64'hA, 0, 0, 0,  1, 1, 1, 64'hA, 2);
    add(1, 64'hD, 1, 0, 1,  0, 1, 1, 64'hA, 2);
    add(1, 64'hD, 1, 0, 1,  0, 1, 1, 64'hA, 2);
    add(1, 64'hD, 1, 0, 1,  0, 1, 1, 64'hA, 2);
    // Fill to FULL, then Flush together with Stall
    add(1, 64'hB, 0, 0, 0,  1, 2, 1, 64'hA, 2);
    add(1, 64'hC, 1, 1, 1,  0, 0, 0, 64'h0, 2);
    add(0, 64'h0, 0, 0, 0,  1, 0, 0, 64'h0, 2);
    // Flush does not clear or block the bubble counter; Stall blocks it
    add(0, 64'h0, 1, 1, 0,  0, 0, 0, 64'h0, 3);
    add(0, 64'h0, 1, 0, 1,  0, 0, 0, 64'h0, 3);
    // Flush in ONE with an offer pending: the offer is not taken
    add(1, 64'h5, 0, 0, 0,  1, 1, 1, 64'h5, 3);
    add(1, 64'h6, 1, 1, 0,  0, 0, 0, 64'h0, 3);
    // Ordering through FULL -> ONE -> ONE(replace) -> EMPTY
    add(1, 64'h7, 0, 0, 0,  1, 1, 1, 64'h7, 3);
    add(1, 64'h8, 0, 0, 0,  1, 2, 1, 64'h7, 3);
    add(1, 64'h9, 1, 0, 0,  0, 1, 1, 64'h8, 3);
    add(1, 64'h9, 1, 0, 0,  1, 1, 1, 64'h9, 3);
    add(0, 64'h0, 1, 0, 0,  1, 0, 0, 64'h0, 3);

    drive(0, 64'h0, 0, 0, 0);
    sat_out_ready = 1'b0;
    sat_rst_n     = 1'b0;
    Reset_n       = 1'b0;
    #2;
    check("reset_count",  {62'h0, Count}, 64'h0);
    check("reset_valid",  {63'h0, OutValid}, 64'h0);
    check("reset_data",   OutData, 64'h0);
    check("reset_bubble", {48'h0, BubbleCount}, 64'h0);
    check("reset_ready",  {63'h0, InReady}, 64'h1);

    @(negedge Clock);
    Reset_n   = 1'b1;
    sat_rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f, vecs[i].s);
      #1;
      check($sformatf("v%0d_in_ready", i), {63'h0, InReady}, {63'h0, vecs[i].ir});
      @(posedge Clock);
      #1;
      check($sformatf("v%0d_count", i),  {62'h0, Count}, {62'h0, vecs[i].cnt});
      check($sformatf("v%0d_valid", i),  {63'h0, OutValid}, {63'h0, vecs[i].ov});
      check($sformatf("v%0d_data", i),   OutData, vecs[i].od);
      check($sformatf("v%0d_bubble", i), {48'h0, BubbleCount}, {48'h0, vecs[i].bc});
      @(negedge Clock);
    end

    // Reset mid-operation: fill to FULL, then drop Reset_n between edges.
    drive(1, 64'h21, 0, 0, 0);
    @(posedge Clock); @(negedge Clock);
    drive(1, 64'h22, 0, 0, 0);
    @(posedge Clock); @(negedge Clock);
    drive(0, 64'h0, 0, 0, 0);
    check("pre_reset_count", {62'h0, Count}, 64'h2);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_reset_valid",  {63'h0, OutValid}, 64'h0);
    check("async_reset_data",   OutData, 64'h0);
    check("async_reset_count",  {62'h0, Count}, 64'h0);
    check("async_reset_bubble", {48'h0, BubbleCount}, 64'h0);
    @(negedge Clock);
    Reset_n = 1'b1;
    // First edge after reset behaves as EMPTY: one entry, the new one.
    drive(1, 64'h33, 0, 0, 0);
    @(posedge Clock);
    #1;
    check("post_reset_count", {62'h0, Count}, 64'h1);
    check("post_reset_data",  OutData, 64'h33);
    @(negedge Clock);
    drive(0, 64'h0, 1, 0, 0);
    @(posedge Clock);
    #1;
    check("post_reset_drain", {62'h0, Count}, 64'h0);
    @(negedge Clock);
    drive(0, 64'h0, 0, 0, 0);

    // Saturation on the 2-bit counter instance: 1,2,3,3,3.
    check("sat_start", {62'h0, sat_bubble}, 64'h0);
    sat_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] exp_b;
      exp_b = (k < 3) ? 2'(k + 1) : 2'd3;
      @(posedge Clock);
      #1;
      check($sformatf("sat_bubble_%0d", k), {62'h0, sat_bubble}, {62'h0, exp_b});
      @(negedge Clock);
    end
    sat_out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
